pulse_stretch: RTL
==================

// Module: pulse_stretch
// PURPOSE
//   Converts one-cycle active-low event pulses back into active-low levels of
//   fixed length HOLD_CYCLES, separated by at least GAP_CYCLES of inactive time.
//   Sits downstream of one-pulsed event sources, driving LEDs, buzzers and
//   slow peripherals that cannot see a single-cycle pulse.
//   Events arriving while busy either extend the current level (retrigger mode)
//   or are queued in a saturating pending counter and replayed in order.
// PARAMETERS
//   HOLD_CYCLES  8   cycles signal_stretched_n is held low per event (1..65535)
//   GAP_CYCLES   2   minimum high cycles between consecutive levels (1..65535)
//   PEND_MAX     3   pending-event capacity (1..255); PEND_W = clog2(PEND_MAX+1)
// PORTS
//   clk_op              in   1       clock, all logic on rising edge
//   reset_n             in   1       asynchronous reset, active-low
//   pulse_n             in   1       event input, active-low; each low sample = 1 event
//   retrigger           in   1       1: event during HOLD restarts hold; 0: event queued
//   ovf_clr_n           in   1       synchronous clear of overflow, active-low
//   signal_stretched_n  out  1       stretched level, active-low (registered)
//   busy                out  1       high whenever state != IDLE (registered)
//   pending             out  PEND_W  queued events not yet replayed (registered)
//   overflow            out  1       sticky: an event was dropped at PEND_MAX
// BEHAVIOUR
//   Reset (async, reset_n low): state IDLE, signal_stretched_n=1, busy=0,
//     pending=0, overflow=0, counters 0. Reset mid-operation aborts
//     immediately; queued events are discarded.
//   Event = pulse_n sampled 0 at a rising edge. Consecutive low cycles count
//     as separate events.
//   FSM (one down-counter cnt, width clog2(max(HOLD,GAP)+1)):
//   IDLE: event -> HOLD, cnt=HOLD_CYCLES-1. Else stay.
//   HOLD: signal_stretched_n=0. cnt decrements each cycle.
//     event & retrigger=1 -> cnt reloaded to HOLD_CYCLES-1 (incl. on cnt==0).
//     event & retrigger=0 -> pending+1; if pending==PEND_MAX, event dropped,
//       overflow<=1.
//     cnt==0 and no retrigger reload -> GAP, cnt=GAP_CYCLES-1.
//   GAP: signal_stretched_n=1. Any event (retrigger ignored) queues as above.
//     cnt==0: if pending>0 or event this cycle -> HOLD, cnt=HOLD_CYCLES-1,
//       consume one event; else -> IDLE.
//   Simultaneous queue + consume in one cycle: pending unchanged. An event on
//     the final GAP cycle with pending==0 goes straight to HOLD and does not
//     touch pending or overflow.
//   Latency: event sampled at edge k -> signal_stretched_n low after edge k+1,
//     held low exactly HOLD_CYCLES cycles, high after edge k+1+HOLD_CYCLES.
//   busy follows state: 1 in HOLD and GAP, 0 in IDLE.
//   overflow: set per rules above; cleared only by reset or ovf_clr_n=0.
//     Set and clear in the same cycle -> set wins.
//   pending saturates at PEND_MAX and never wraps.
// TESTING (HOLD=8, GAP=2, PEND_MAX=3 unless noted)
//   Single pulse at edge 10 -> out low 11..18, high 19; busy 1 on 11..20;
//     IDLE at 21; pending stays 0.
//   retrigger=1, pulses at edges 10 and 15 -> out low continuously 11..23,
//     pending 0.
//   retrigger=0, pulses at 10,12,14 -> pending 2 by edge 15; out low 11-18,
//     21-28, 31-38; busy 0 from 41.
//   retrigger=0, 5 pulses at edges 11..15 -> pending 3, overflow 1; 3 more
//     levels, then IDLE; ovf_clr_n=0 for 1 cycle -> overflow 0.
//   Pulse on final GAP cycle (edge 20 after pulse at 10) -> low 21..28,
//     no IDLE cycle in between; pending 0.
//   reset_n low mid-HOLD with pending=2 -> out=1, busy=0, pending=0
//     immediately; next pulse behaves as in test 1.

Source files
------------

// File: rtl/pulse_stretch.sv
// Stretches one-cycle active-low event pulses into fixed-length active-low levels
// separated by a minimum gap; busy events either retrigger the hold or are queued.
module pulse_stretch #(
   parameter  int unsigned HOLD_CYCLES = 8,
   parameter  int unsigned GAP_CYCLES  = 2,
   parameter  int unsigned PEND_MAX    = 3,
   localparam int unsigned PEND_W      = $clog2(PEND_MAX + 1)
) (
   input  logic              clk_op,
   input  logic              reset_n,
   input  logic              pulse_n,
   input  logic              retrigger,
   input  logic              ovf_clr_n,
   output logic              signal_stretched_n,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

   localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      GAP
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic              out_n_q, out_n_d;
   logic              busy_q, busy_d;

   logic ev;
   logic queue;
   logic consume;

   assign ev = ~pulse_n;

   always_ff @(posedge clk_op or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         out_n_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         out_n_q <= out_n_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      queue   = 1'b0;
      consume = 1'b0;
      case (state_q)
         IDLE: begin
            if (ev) begin
               state_d = HOLD;
               cnt_d   = HOLD_LOAD;
            end
         end
         HOLD: begin
            if (ev && retrigger) begin
               cnt_d = HOLD_LOAD;
            end else begin
               queue = ev;
               if (cnt_q == '0) begin
                  state_d = GAP;
                  cnt_d   = GAP_LOAD;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               if (pend_q != '0) begin
                  state_d = HOLD;
                  cnt_d   = HOLD_LOAD;
                  consume = 1'b1;
                  queue   = ev;
               end else if (ev) begin
                  // fresh event on the last gap cycle bypasses the queue entirely
                  state_d = HOLD;
                  cnt_d   = HOLD_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
               queue = ev;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // queue bookkeeping; a queued event paired with a consume leaves the count as is
   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q & ovf_clr_n;
      if (queue && !consume) begin
         if (pend_q == PEND_FULL) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + 1'b1;
         end
      end else if (consume && !queue) begin
         pend_d = pend_q - 1'b1;
      end
   end

   always_comb begin
      out_n_d = (state_q != HOLD);
      busy_d  = (state_q != IDLE);
   end

   assign signal_stretched_n = out_n_q;
   assign busy               = busy_q;
   assign pending            = pend_q;
   assign overflow           = ovf_q;

endmodule
